// File: rtl/uart_rgb_cmd.sv
// ASCII brightness command parser (<C><H><H><CR|LF>) driving three PWM
// channels, with a one-byte 'K'/'E' reply toward the UART transmitter.
module uart_rgb_cmd #(
  parameter int PWM_BITS    = 8,
  parameter int CMD_TIMEOUT = 12000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                pwm_red,
  output logic                pwm_green,
  output logic                pwm_blue,
  output logic [PWM_BITS-1:0] duty_red,
  output logic [PWM_BITS-1:0] duty_green,
  output logic [PWM_BITS-1:0] duty_blue,
  output logic                cmd_err,
  output logic [2:0]          dbg_state
);

  localparam int TW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [7:0] ACK_K = 8'h4B;
  localparam logic [7:0] ACK_E = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HI      = 3'd1,
    S_LO      = 3'd2,
    S_TERM    = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 sel_q, sel_d;     // bit0 red, bit1 green, bit2 blue
  logic [7:0]                 val_q, val_d;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic [2:0][PWM_BITS-1:0]   shadow_q, shadow_d;
  logic [2:0][PWM_BITS-1:0]   duty_q, duty_d;
  logic [PWM_BITS-1:0]        cnt_q, cnt_d;
  logic [2:0]                 pwm_q, pwm_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       tx_valid_q, tx_valid_d;
  logic                       cmd_err_q, cmd_err_d;
  logic                       ok, err;

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  // Letters A-F/a-f have low nibble 1..6, so adding 9 yields 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
  endfunction

  function automatic logic [2:0] chan_mask(input logic [7:0] b);
    case (b)
      8'h52, 8'h72: return 3'b001;
      8'h47, 8'h67: return 3'b010;
      8'h42, 8'h62: return 3'b100;
      8'h57, 8'h77: return 3'b111;
      default:      return 3'b000;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    val_d    = val_q;
    tmo_d    = tmo_q;
    shadow_d = shadow_q;
    ok       = 1'b0;
    err      = 1'b0;
    if (rx_valid) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (chan_mask(rx_data) != 3'b000) begin
            sel_d   = chan_mask(rx_data);
            state_d = S_HI;
          end else if (!is_term(rx_data)) begin
            err     = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_HI: begin
          if (is_hex(rx_data)) begin
            val_d[7:4] = hex_val(rx_data);
            state_d    = S_LO;
          end else begin
            err     = 1'b1;
            state_d = is_term(rx_data) ? S_IDLE : S_DISCARD;
          end
        end
        S_LO: begin
          if (is_hex(rx_data)) begin
            val_d[3:0] = hex_val(rx_data);
            state_d    = S_TERM;
          end else begin
            err     = 1'b1;
            state_d = is_term(rx_data) ? S_IDLE : S_DISCARD;
          end
        end
        S_TERM: begin
          if (is_term(rx_data)) begin
            ok      = 1'b1;
            state_d = S_IDLE;
            for (int i = 0; i < 3; i++) begin
              if (sel_q[i]) shadow_d[i] = PWM_BITS'(val_q);
            end
          end else begin
            err     = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: if (is_term(rx_data)) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end else if (state_q == S_HI || state_q == S_LO || state_q == S_TERM) begin
      if (tmo_q == TW'(CMD_TIMEOUT - 1)) begin
        err     = 1'b1;
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Reply handshake: a byte moves on a cycle where tx_valid && tx_ready.
  // tx_data is frozen while tx_valid is high and unaccepted; a newer reply
  // replaces the pending one (latest wins), even in the accept cycle.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    cmd_err_d  = err;
    if (ok) begin
      tx_valid_d = 1'b1;
      tx_data_d  = ACK_K;
    end else if (err) begin
      tx_valid_d = 1'b1;
      tx_data_d  = ACK_E;
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  // Duty reload on the last count keeps each PWM period glitch-free; the
  // compare uses next-cycle counter/duty so the registered output lines up.
  always_comb begin
    cnt_d  = cnt_q + PWM_BITS'(1);
    duty_d = (cnt_q == '1) ? shadow_d : duty_q;
    for (int i = 0; i < 3; i++) pwm_d[i] = (cnt_d < duty_d[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      val_q      <= '0;
      tmo_q      <= '0;
      shadow_q   <= '0;
      duty_q     <= '0;
      cnt_q      <= '0;
      pwm_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      val_q      <= val_d;
      tmo_q      <= tmo_d;
      shadow_q   <= shadow_d;
      duty_q     <= duty_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign cmd_err    = cmd_err_q;
  assign pwm_red    = pwm_q[0];
  assign pwm_green  = pwm_q[1];
  assign pwm_blue   = pwm_q[2];
  assign duty_red   = duty_q[0];
  assign duty_green = duty_q[1];
  assign duty_blue  = duty_q[2];
  assign dbg_state  = state_q;

endmodule

// File: doc/uart_rgb_cmd.md
Name: uart_rgb_cmd

Overview:
- Sits directly downstream of the simpleuart receive path and directly upstream of the SB_RGBA_DRV PWM inputs.
- Parses 4-byte ASCII brightness commands from the UART byte stream.
- Drives three glitch-free PWM outputs into the RGB driver.
- Sends a one-byte acknowledge ('K') or error ('E') back to the UART transmit path.

Parameters:
PWM_BITS, 8, width of PWM counter and duty registers; fixed at 8 for the 2-hex-digit grammar.
CMD_TIMEOUT, 12000000, idle cycles allowed between bytes of one command (1 s at 12 MHz).

Ports:
clk  in  1  single system clock (12 MHz from SB_HFOSC)
rst  in  1  asynchronous, active-high reset
rx_data  in  8  received byte from UART
rx_valid  in  1  one-cycle strobe: rx_data valid
tx_data  out  8  reply byte to UART
tx_valid  out  1  reply pending; held until accepted
tx_ready  in  1  UART can accept a byte; transfer when tx_valid&&tx_ready
pwm_red  out  1  to RGB2PWM
pwm_green  out  1  to RGB0PWM
pwm_blue  out  1  to RGB1PWM
duty_red  out  8  active red duty
duty_green  out  8  active green duty
duty_blue  out  8  active blue duty
cmd_err  out  1  one-cycle pulse on any command error

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - FSM=IDLE; all duty_* and shadow duties = 0.
  - PWM counter = 0; pwm_* = 0.
  - tx_valid = 0; tx_data = 0; cmd_err = 0; timeout counter = 0.
- Command grammar: <C><H><H><T>.
  - C in R,G,B,W (either case); W selects all three channels.
  - H is a hex digit 0-9, A-F, a-f; first H is the high nibble.
  - T is CR (0x0D) or LF (0x0A).
- FSM, advancing only on cycles with rx_valid=1:
  - IDLE: C -> HI (latch channel select). CR/LF -> IDLE, silent (allows CRLF). Any other byte -> DISCARD with error.
  - HI: hex -> LO (latch high nibble). Else -> error; if the byte was CR/LF go IDLE, otherwise go DISCARD.
  - LO: hex -> TERM (latch low nibble). Else -> error, same rule as HI.
  - TERM: CR/LF -> IDLE; write the value to the selected shadow duty register(s); reply 'K' (0x4B). Else -> DISCARD with error.
  - DISCARD: CR/LF -> IDLE; all other bytes ignored; no further replies.
- Error action: cmd_err pulses 1 cycle; reply 'E' (0x45); no duty change.
- Timeout:
  - Counter clears on every rx_valid.
  - In HI/LO/TERM, reaching CMD_TIMEOUT cycles -> IDLE with error.
  - IDLE and DISCARD never time out.
- Reply path:
  - One-entry buffer. tx_data/tx_valid are registered 1 cycle after the deciding byte's rx_valid.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
  - tx_valid clears the cycle after acceptance.
  - A new reply generated while one is pending overwrites it (latest wins); if generated in the accept cycle, tx_valid stays 1 with the new byte.
- PWM:
  - Free-running 8-bit counter, 0..255, wraps to 0.
  - Active duty registers load from shadow when counter==255 (applied from count 0).
  - pwm_x = (counter < duty_x), registered; duty 0 -> constant 0, duty 255 -> high 255 of 256 cycles.
  - duty_* outputs show active (not shadow) values.
  - A shadow write and a load in the same cycle: the new value loads.
- Reset mid-command: FSM returns to IDLE, duties go to 0, any pending reply is dropped.

Test Plan:
- After reset, bytes "R80\r" -> tx 'K' 1 cycle after '\r'; duty_red=0x80 after next wrap; pwm_red high exactly 128 of 256 cycles; green/blue stay 0.
- "Wff\n" then "g0A\r\n" -> two 'K'; duty_red=duty_blue=0xFF, duty_green=0x0A; trailing '\n' produces no reply.
- "X12\r" -> single 'E', one cmd_err pulse; "R1Z\r" -> single 'E'; duties unchanged.
- "G1", then 12000000 idle cycles -> 'E' and FSM IDLE; then "G10\r" -> 'K', duty_green=0x10.
- tx_ready held low for 100 cycles after "B40\r" -> tx_valid=1, tx_data=0x4B stable for the whole window; one transfer when ready rises.
- Assert rst after "R8" -> all outputs return to reset values; then "R33\r" -> 'K', duty_red=0x33.
